// File: rtl/or4_response_checker.sv
// ---------------------------------------------------------------------------
// or4_response_checker
//
// Self-check monitor for a 4-input OR block (aa,bb,cc,dd -> ee,ff,gg).
// It watches the stimulus driven into that block and the block's response.
// After every stimulus change it waits SETTLE cycles of stable stimulus, then
// compares the response against ee=aa|bb, ff=cc|dd, gg=aa|bb|cc|dd. While the
// stimulus stays put after a compare, any change in the response is counted as
// a glitch. Check and error counts feed a lab bench or FPGA LEDs.
//
// Parameters
//   SETTLE   cycles of stable stimulus before a compare (1..255)
//   CNT_W    width of check_cnt / err_cnt
//   MAX_ERR  err_cnt value at which checking halts (< 2**CNT_W)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           enable checking (leaving it low parks the checker in IDLE)
//   clr          synchronous clear of counters/flags, also leaves HALT
//   aa,bb,cc,dd  stimulus seen by the checked block
//   ee,ff,gg     response of the checked block
//   state        IDLE=0 SETTLE=1 CHECK=2 HOLD=3 HALT=4
//   check_cnt    compares performed (saturating)
//   err_cnt      mismatches plus glitches (saturating)
//   err_flag     sticky, set on the first error
//   err_vec      {ee,ff,gg} bits that were wrong at the most recent error
//   pass         en & (check_cnt != 0) & (err_cnt == 0)
// ---------------------------------------------------------------------------
module or4_response_checker #(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_ERR = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             aa,
    input  logic             bb,
    input  logic             cc,
    input  logic             dd,
    input  logic             ee,
    input  logic             ff,
    input  logic             gg,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] check_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [2:0]       err_vec,
    output logic             pass
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [7:0]       SETTLE_LD = 8'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] ERR_LIMIT = CNT_W'(MAX_ERR);

    state_t           st;
    logic [3:0]       stim_q;
    logic [2:0]       resp_q;
    logic [7:0]       scnt;

    logic [3:0]       stim;
    logic [2:0]       resp;
    logic [2:0]       expected;
    logic             stim_changed;
    logic [CNT_W-1:0] chk_inc;
    logic [CNT_W-1:0] err_inc;

    assign stim         = {aa, bb, cc, dd};
    assign resp         = {ee, ff, gg};
    assign expected     = {stim_q[3] | stim_q[2], stim_q[1] | stim_q[0], |stim_q};
    assign stim_changed = (stim != stim_q);

    // Saturating increments: counters stick at all-ones rather than wrapping.
    assign chk_inc = (check_cnt == CNT_MAX) ? check_cnt : check_cnt + CNT_W'(1);
    assign err_inc = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);

    assign state = st;
    assign pass  = en & (check_cnt != '0) & (err_cnt == '0);

    // Checker FSM. Priority on each edge: clr, then HALT (frozen), then en=0,
    // then the normal state transition. A stimulus change in SETTLE, CHECK or
    // HOLD always restarts the settle window and wins over any response change
    // on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            stim_q    <= '0;
            resp_q    <= '0;
            scnt      <= '0;
            check_cnt <= '0;
            err_cnt   <= '0;
            err_flag  <= 1'b0;
            err_vec   <= '0;
        end else if (clr) begin
            st        <= ST_IDLE;
            check_cnt <= '0;
            err_cnt   <= '0;
            err_flag  <= 1'b0;
            err_vec   <= '0;
        end else if (st == ST_HALT) begin
            st <= ST_HALT;
        end else if (!en) begin
            st <= ST_IDLE;
        end else begin
            case (st)
                ST_IDLE: begin
                    st     <= ST_SETTLE;
                    stim_q <= stim;
                    scnt   <= SETTLE_LD;
                end
                ST_SETTLE: begin
                    if (stim_changed) begin
                        stim_q <= stim;
                        scnt   <= SETTLE_LD;
                    end else if (scnt == 8'd1) begin
                        st <= ST_CHECK;
                    end else begin
                        scnt <= scnt - 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (stim_changed) begin
                        st     <= ST_SETTLE;
                        stim_q <= stim;
                        scnt   <= SETTLE_LD;
                    end else begin
                        check_cnt <= chk_inc;
                        resp_q    <= resp;
                        if (resp != expected) begin
                            err_cnt  <= err_inc;
                            err_flag <= 1'b1;
                            err_vec  <= resp ^ expected;
                            st       <= (err_inc >= ERR_LIMIT) ? ST_HALT : ST_HOLD;
                        end else begin
                            st <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // The response was already judged; any later movement
                    // with stable stimulus is a glitch, not a new compare.
                    if (stim_changed) begin
                        st     <= ST_SETTLE;
                        stim_q <= stim;
                        scnt   <= SETTLE_LD;
                    end else if (resp != resp_q) begin
                        err_cnt  <= err_inc;
                        err_flag <= 1'b1;
                        err_vec  <= resp_q ^ resp;
                        resp_q   <= resp;
                        if (err_inc >= ERR_LIMIT) begin
                            st <= ST_HALT;
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
